// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM port arbiter: VGA scan-out reads win by default, processor writes are
// buffered in a small FIFO and forced through after STARVE_LIMIT denied cycles.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        cpu_wr_req,
  input  logic [ADDR_W-1:0]           cpu_wr_addr,
  input  logic [DATA_W-1:0]           cpu_wr_data,
  output logic                        cpu_wr_ready,
  input  logic                        vga_rd_req,
  input  logic [ADDR_W-1:0]           vga_rd_addr,
  output logic [DATA_W-1:0]           vga_rd_data,
  output logic                        vga_rd_valid,
  output logic                        vga_rd_miss,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic                        mem_we,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_RD   = 2'd1,
    GNT_WR   = 2'd2
  } grant_e;

  grant_e              grant_q, grant_d;
  logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [SC_W-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_stage_q, rd_valid_q;
  logic                drop_q, drop_dly_q, miss_q;

  logic                fifo_empty_s;
  logic                force_wr_s;
  logic                push_s;
  logic                pop_s;

  assign fifo_empty_s = (count_q == CNT_W'(0));
  assign cpu_wr_ready = (count_q < CNT_W'(FIFO_DEPTH));
  assign push_s       = cpu_wr_req & cpu_wr_ready;
  assign force_wr_s   = !fifo_empty_s && (starve_q >= SC_W'(STARVE_LIMIT));
  assign pop_s        = (grant_d == GNT_WR);

  // Grant priority: starvation override, then scan-out read, then pending write.
  always_comb begin
    grant_d = GNT_IDLE;
    if (force_wr_s) begin
      grant_d = GNT_WR;
    end else if (vga_rd_req) begin
      grant_d = GNT_RD;
    end else if (!fifo_empty_s) begin
      grant_d = GNT_WR;
    end else begin
      grant_d = GNT_IDLE;
    end
  end

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    rd_data_d   = rd_data_q;

    case (grant_d)
      GNT_RD: begin
        mem_addr_d = vga_rd_addr;
      end
      GNT_WR: begin
        mem_addr_d  = fifo_addr_q[rd_ptr_q];
        mem_wdata_d = fifo_data_q[rd_ptr_q];
        mem_we_d    = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end
      default: begin
        mem_we_d = 1'b0;
      end
    endcase

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Denied-write counter saturates so the force condition stays asserted until served.
    if (fifo_empty_s || pop_s) begin
      starve_d = SC_W'(0);
    end else if (starve_q < SC_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + SC_W'(1);
    end else begin
      starve_d = starve_q;
    end

    if (rd_stage_q) begin
      rd_data_d = mem_rdata;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q     <= GNT_IDLE;
      wr_ptr_q    <= PTR_W'(0);
      rd_ptr_q    <= PTR_W'(0);
      count_q     <= CNT_W'(0);
      starve_q    <= SC_W'(0);
      mem_addr_q  <= ADDR_W'(0);
      mem_wdata_q <= DATA_W'(0);
      mem_we_q    <= 1'b0;
      rd_data_q   <= DATA_W'(0);
      rd_stage_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
      drop_dly_q  <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      rd_data_q   <= rd_data_d;
      // RAM returns data one cycle after the address cycle; result lands two edges after grant.
      rd_stage_q  <= (grant_q == GNT_RD);
      rd_valid_q  <= rd_stage_q;
      drop_q      <= force_wr_s & vga_rd_req;
      drop_dly_q  <= drop_q;
      miss_q      <= drop_dly_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push_s) begin
      fifo_addr_q[wr_ptr_q] <= cpu_wr_addr;
      fifo_data_q[wr_ptr_q] <= cpu_wr_data;
    end
  end

  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_we       = mem_we_q;
  assign vga_rd_data  = rd_data_q;
  assign vga_rd_valid = rd_valid_q;
  assign vga_rd_miss  = miss_q;
  assign fifo_count   = count_q;

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 19, frame-buffer address width; DATA_W, 8, colour-index width; FIFO_DEPTH, 4, processor write-buffer entries (power of 2); STARVE_LIMIT, 16, consecutive write-denied cycles before a forced write.
REQ-002 Ports (name, direction, width, meaning):
- clock, in, 1: single clock for all logic.
- reset, in, 1: asynchronous, active-high.
- cpu_wr_req, in, 1: processor write request.
- cpu_wr_addr, in, ADDR_W: processor write address.
- cpu_wr_data, in, DATA_W: processor write data.
- cpu_wr_ready, out, 1: write FIFO not full.
- vga_rd_req, in, 1: scan-out read request.
- vga_rd_addr, in, ADDR_W: scan-out read address.
- vga_rd_data, out, DATA_W: read data returned.
- vga_rd_valid, out, 1: vga_rd_data valid this cycle.
- vga_rd_miss, out, 1: one-cycle pulse when a read was dropped.
- mem_addr, out, ADDR_W: frame-buffer RAM address, registered.
- mem_wdata, out, DATA_W: RAM write data, registered.
- mem_we, out, 1: RAM write enable, registered.
- mem_rdata, in, DATA_W: RAM read data, valid one cycle after mem_addr.
- fifo_count, out, log2(FIFO_DEPTH)+1: current write-FIFO occupancy.

Function
REQ-003 Write FIFO accepts an entry on an edge where cpu_wr_req=1 and cpu_wr_ready=1; cpu_wr_ready = (fifo_count < FIFO_DEPTH), computed from the pre-edge count only.
- At full, a push is refused even if a pop occurs on the same edge.
REQ-004 Push and pop on the same edge leave fifo_count unchanged; pointers wrap modulo FIFO_DEPTH; entries drain in FIFO order.
REQ-005 Grant register holds one of three states: IDLE, RD, WR.
- On each edge the grant is chosen from the inputs sampled at that edge and applies to the following cycle.
REQ-006 Arbitration order on each edge:
- (a) force condition (starve_cnt >= STARVE_LIMIT and FIFO non-empty) -> WR;
- (b) else vga_rd_req=1 -> RD;
- (c) else FIFO non-empty -> WR;
- (d) else IDLE.
REQ-007 RD grant: mem_addr<=vga_rd_addr and mem_we<=0 at the grant edge; vga_rd_data<=mem_rdata and vga_rd_valid<=1 two edges after the request edge.
- Read latency is fixed at 2 cycles; back-to-back reads give one valid result per cycle.
REQ-008 WR grant: mem_addr, mem_wdata <= FIFO head entry, mem_we<=1 for exactly one cycle; the FIFO pops on the same edge.
REQ-009 IDLE grant: mem_we<=0; mem_addr and mem_wdata hold their previous values.
REQ-010 starve_cnt (internal, saturating at STARVE_LIMIT):
- increments on every edge where the FIFO is non-empty and WR is not granted;
- clears on any WR grant;
- clears when the FIFO is empty.
REQ-011 If WR is forced while vga_rd_req=1, that read is dropped.
- No vga_rd_valid is produced for it.
- vga_rd_miss pulses high one cycle, aligned to the cycle its vga_rd_valid would have occupied (2 cycles after the request).
REQ-012 vga_rd_valid and vga_rd_miss are never high together; mem_we and a read grant are never active in the same cycle.
REQ-013 Read-after-write to the same address needs no bypass: ordering follows grant order, and a read granted after the WR cycle returns the new data.

Reset
REQ-014 Reset is asynchronous and active-high. While reset=1 and on its release:
- grant=IDLE, FIFO empty, fifo_count=0, starve_cnt=0;
- cpu_wr_ready=1 (combinational from count);
- mem_we=0, mem_addr=0, mem_wdata=0;
- vga_rd_data=0, vga_rd_valid=0, vga_rd_miss=0.
REQ-015 Reset asserted mid-operation discards all buffered writes and in-flight reads; no mem_we pulse and no vga_rd_valid occur after reset assertion.

Verification
REQ-016 Single write: push addr 0x00010 data 0x5A with VGA idle -> mem_we=1, mem_addr=0x00010, mem_wdata=0x5A in the cycle after the push, then fifo_count=0.
REQ-017 Read latency: vga_rd_req at edge k with addr 0x00020 and RAM model holding 0x33 -> vga_rd_valid=1 and vga_rd_data=0x33 after edge k+2.
REQ-018 Full FIFO: 5 consecutive pushes with vga_rd_req held 1 -> 4 accepted, cpu_wr_ready=0 on the 5th, fifo_count=4.
REQ-019 Starvation: FIFO non-empty and vga_rd_req held 1 for 20 cycles -> forced WR on the 17th edge, exactly one vga_rd_miss pulse, starve_cnt restarts.
REQ-020 Simultaneous push/pop: fifo_count=2 with a push on the same edge as a WR pop -> fifo_count stays 2 and drain order is preserved.
REQ-021 Reset mid-stream: reset asserted with fifo_count=3 and a read in flight -> all outputs at reset values asynchronously, no later mem_we or vga_rd_valid.
